// File: rtl/riscv_soft_axil_pkg.sv
// riscv_soft_axil_pkg: response codes and index/slice helpers shared by the AXI4-Lite register file
package riscv_soft_axil_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic int idx_width(input int addr_width, input int data_width);
    return addr_width - $clog2(data_width / 8);
  endfunction
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction
endpackage

// File: rtl/riscv_soft_axil_wr_capture.sv
// riscv_soft_axil_wr_capture: independent AW/W holding registers, commit fires once both sides are present
module riscv_soft_axil_wr_capture #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic                    bvalid,
  output logic                    commit,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH/8-1:0] strb
);
  logic aw_held, w_held, aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  assign awready = !aw_held && !bvalid;
  assign wready = !w_held && !bvalid;
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  // A side completing this cycle is used directly, so the commit lands on its handshake edge
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);
  assign addr = aw_held ? addr_q : awaddr;
  assign data = w_held ? data_q : wdata;
  assign strb = w_held ? strb_q : wstrb;
  always_ff @(posedge clk)
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
    end else begin
      aw_held <= commit ? 1'b0 : aw_held || aw_hs;
      w_held <= commit ? 1'b0 : w_held || w_hs;
    end
  always_ff @(posedge clk) begin
    if (aw_hs) addr_q <= awaddr;
    if (w_hs) begin
      data_q <= wdata;
      strb_q <= wstrb;
    end
  end
endmodule

// File: rtl/riscv_soft_axi_lite_regfile.sv
// riscv_soft_axi_lite_regfile: AXI4-Lite slave register file with RW storage and RO status windows
// Define RISCV_SOFT_AXIL_WR_PULSE_EN to build per-register write-commit pulses on wr_pulse_o.
module riscv_soft_axi_lite_regfile
  import riscv_soft_axil_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 5,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int IW = idx_width(ADDR_WIDTH, DATA_WIDTH);
  logic [NUM_REGS*DATA_WIDTH-1:0] store;
  logic commit, wr_ok, rd_in, ar_hs, unused_addr_bits;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, rd_word;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [NUM_REGS-1:0] wr_ro, rd_ro;
  riscv_soft_axil_wr_capture #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_capture (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .awaddr(S_AXI_AWADDR), .awvalid(S_AXI_AWVALID), .awready(S_AXI_AWREADY),
    .wdata(S_AXI_WDATA), .wstrb(S_AXI_WSTRB), .wvalid(S_AXI_WVALID), .wready(S_AXI_WREADY),
    .bvalid(S_AXI_BVALID), .commit(commit), .addr(wr_addr), .data(wr_data), .strb(wr_strb)
  );
  assign regs_o = store;
  assign wr_idx = wr_addr[ADDR_WIDTH-1:OFF];
  assign wr_ro = RO_MASK >> wr_idx;
  assign wr_ok = 32'(wr_idx) < NUM_REGS && !wr_ro[0];
  assign rd_idx = S_AXI_ARADDR[ADDR_WIDTH-1:OFF];
  assign rd_ro = RO_MASK >> rd_idx;
  assign rd_in = 32'(rd_idx) < NUM_REGS;
  assign rd_word = DATA_WIDTH'((rd_ro[0] ? status_i : store) >> slice_lsb(int'(rd_idx), DATA_WIDTH));
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign S_AXI_ARREADY = !S_AXI_RVALID;
  assign unused_addr_bits = ^{wr_addr[OFF-1:0], S_AXI_ARADDR[OFF-1:0]};
  always_ff @(posedge S_AXI_ACLK)
    if (!S_AXI_ARESETN) begin
      store <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= RESP_OKAY;
    end else begin
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      for (int b = 0; b < DATA_WIDTH / 8; b++)
        if (commit && wr_ok && wr_strb[b])
          store[slice_lsb(int'(wr_idx), DATA_WIDTH) + b * 8 +: 8] <= wr_data[b*8 +: 8];
    end
  // Read sees storage before any same-edge commit, so a colliding read returns the old value
  always_ff @(posedge S_AXI_ACLK)
    if (!S_AXI_ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP <= RESP_OKAY;
      S_AXI_RDATA <= '0;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA <= rd_in ? rd_word : '0;
      S_AXI_RRESP <= rd_in ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
`ifdef RISCV_SOFT_AXIL_WR_PULSE_EN
  logic [NUM_REGS-1:0] pulse;
  always_ff @(posedge S_AXI_ACLK)
    if (!S_AXI_ARESETN) pulse <= '0;
    else pulse <= commit && wr_ok ? NUM_REGS'(1) << wr_idx : '0;
  assign wr_pulse_o = pulse;
`else
  assign wr_pulse_o = '0;
`endif
endmodule
